psum_stream_checker: RTL and testbench

PSUM_STREAM_CHECKER -- requirements
Module: psum_stream_checker

---
 rtl/psum_stream_checker.sv | 161 ++++++++++++++++
 tb/tb_psum_stream_checker.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/psum_stream_checker.sv
// Compares a DUT psum stream against a golden stream pair by pair and reports results.
// One pair per cycle when both streams are valid in RUN; counts update one cycle after the pair.
// The two streams are only consumed together, so a stall on either side freezes everything.
module psum_stream_checker #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  num_words,
  input  logic                  out_valid,
  input  logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_ready,
  input  logic                  exp_valid,
  input  logic [DATA_WIDTH-1:0] exp_data,
  output logic                  exp_ready,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  match_count,
  output logic [CNT_WIDTH-1:0]  mismatch_count,
  output logic                  mismatch_pulse,
  output logic [CNT_WIDTH-1:0]  mismatch_idx,
  output logic                  first_err_valid,
  output logic [CNT_WIDTH-1:0]  first_err_idx,
  output logic [DATA_WIDTH-1:0] first_err_out,
  output logic [DATA_WIDTH-1:0] first_err_exp
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  state_t                state_q, state_d;
  logic [CNT_WIDTH-1:0]  num_q, num_d;
  logic [CNT_WIDTH-1:0]  idx_q, idx_d;
  logic [CNT_WIDTH-1:0]  match_q, match_d;
  logic [CNT_WIDTH-1:0]  mism_q, mism_d;
  logic                  pulse_q, pulse_d;
  logic [CNT_WIDTH-1:0]  midx_q, midx_d;
  logic                  fev_q, fev_d;
  logic [CNT_WIDTH-1:0]  feidx_q, feidx_d;
  logic [DATA_WIDTH-1:0] feout_q, feout_d;
  logic [DATA_WIDTH-1:0] feexp_q, feexp_d;

  logic                  pair_fire;
  logic                  pair_mis;
  logic [CNT_WIDTH-1:0]  idx_nxt;

  // Saturating increment: counters stick at all-ones rather than wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  // Handshake: each stream is accepted only when its partner is also offering a word.
  assign out_ready = (state_q == S_RUN) && exp_valid;
  assign exp_ready = (state_q == S_RUN) && out_valid;
  assign pair_fire = (state_q == S_RUN) && out_valid && exp_valid;
  assign pair_mis  = (out_data != exp_data);
  assign idx_nxt   = sat_inc(idx_q);

  // Next-state: run control, pair accounting and first-error capture.
  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    idx_d   = idx_q;
    match_d = match_q;
    mism_d  = mism_q;
    pulse_d = 1'b0;
    midx_d  = midx_q;
    fev_d   = fev_q;
    feidx_d = feidx_q;
    feout_d = feout_q;
    feexp_d = feexp_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          num_d   = num_words;
          idx_d   = CNT_ZERO;
          match_d = CNT_ZERO;
          mism_d  = CNT_ZERO;
          midx_d  = CNT_ZERO;
          fev_d   = 1'b0;
          feidx_d = CNT_ZERO;
          feout_d = '0;
          feexp_d = '0;
          state_d = (num_words == CNT_ZERO) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (pair_fire) begin
          idx_d = idx_nxt;
          if (pair_mis) begin
            mism_d  = sat_inc(mism_q);
            pulse_d = 1'b1;
            midx_d  = idx_nxt;
            if (!fev_q) begin
              fev_d   = 1'b1;
              feidx_d = idx_nxt;
              feout_d = out_data;
              feexp_d = exp_data;
            end
          end else begin
            match_d = sat_inc(match_q);
          end
          if (idx_nxt == num_q) begin
            state_d = S_DONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register; reset wipes every result so an aborted run leaves nothing behind.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      num_q   <= '0;
      idx_q   <= '0;
      match_q <= '0;
      mism_q  <= '0;
      pulse_q <= 1'b0;
      midx_q  <= '0;
      fev_q   <= 1'b0;
      feidx_q <= '0;
      feout_q <= '0;
      feexp_q <= '0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      idx_q   <= idx_d;
      match_q <= match_d;
      mism_q  <= mism_d;
      pulse_q <= pulse_d;
      midx_q  <= midx_d;
      fev_q   <= fev_d;
      feidx_q <= feidx_d;
      feout_q <= feout_d;
      feexp_q <= feexp_d;
    end
  end

  assign busy            = (state_q == S_RUN);
  assign done            = (state_q == S_DONE);
  assign match_count     = match_q;
  assign mismatch_count  = mism_q;
  assign mismatch_pulse  = pulse_q;
  assign mismatch_idx    = midx_q;
  assign first_err_valid = fev_q;
  assign first_err_idx   = feidx_q;
  assign first_err_out   = feout_q;
  assign first_err_exp   = feexp_q;

endmodule

// File: tb/tb_psum_stream_checker.sv
// Bench for psum_stream_checker: directed scenarios plus randomized runs with stalls.
// Expected results come from a list-level model of each run, queued at issue time.
// A negedge monitor pops expected mismatch indices and final results as the DUT reports them.
module tb_psum_stream_checker;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] num_words;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_ready;
  logic        exp_valid;
  logic [15:0] exp_data;
  logic        exp_ready;
  logic        busy;
  logic        done;
  logic [15:0] match_count;
  logic [15:0] mismatch_count;
  logic        mismatch_pulse;
  logic [15:0] mismatch_idx;
  logic        first_err_valid;
  logic [15:0] first_err_idx;
  logic [15:0] first_err_out;
  logic [15:0] first_err_exp;

  psum_stream_checker #(.DATA_WIDTH(16), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .start(start), .num_words(num_words),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .exp_valid(exp_valid), .exp_data(exp_data), .exp_ready(exp_ready),
    .busy(busy), .done(done), .match_count(match_count),
    .mismatch_count(mismatch_count), .mismatch_pulse(mismatch_pulse),
    .mismatch_idx(mismatch_idx), .first_err_valid(first_err_valid),
    .first_err_idx(first_err_idx), .first_err_out(first_err_out),
    .first_err_exp(first_err_exp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          m;
    int          mm;
    bit          fev;
    int          fidx;
    logic [15:0] fo;
    logic [15:0] fe;
  } final_t;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [15:0] ow[$];
  logic [15:0] ew[$];
  int          mm_q[$];
  final_t      fin_q[$];
  logic        done_prev = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_match"}, match_count, 0);
    chk({tag, "_mismatch"}, mismatch_count, 0);
    chk({tag, "_pulse"}, mismatch_pulse, 0);
    chk({tag, "_midx"}, mismatch_idx, 0);
    chk({tag, "_fev"}, first_err_valid, 0);
    chk({tag, "_fidx"}, first_err_idx, 0);
    chk({tag, "_fout"}, first_err_out, 0);
    chk({tag, "_fexp"}, first_err_exp, 0);
    chk({tag, "_out_ready"}, out_ready, 0);
    chk({tag, "_exp_ready"}, exp_ready, 0);
  endtask

  // Monitor: reported mismatches and completed runs are matched against the queued expectations.
  always @(negedge clk) begin
    if (mismatch_pulse) begin
      if (mm_q.size() == 0) chk("unexpected_pulse", 1, 0);
      else chk("mismatch_idx", mismatch_idx, mm_q.pop_front());
    end
    if (done && !done_prev) begin
      if (fin_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        final_t f;
        f = fin_q.pop_front();
        chk("match_count", match_count, f.m);
        chk("mismatch_count", mismatch_count, f.mm);
        chk("first_err_valid", first_err_valid, f.fev);
        chk("first_err_idx", first_err_idx, f.fidx);
        chk("first_err_out", first_err_out, f.fo);
        chk("first_err_exp", first_err_exp, f.fe);
      end
    end
    done_prev = done;
  end

  // Runs one check of n pairs taken from ow/ew. rnd adds random stalls, gap_at holds
  // exp_valid low for two cycles before pair gap_at (0-based), poke pulses start mid-run.
  task automatic do_run(input int n, input bit rnd, input int gap_at, input bit poke);
    final_t f;
    int     k, cyc, gap;
    bit     ov, ev, mm_prev;
    f.m = 0; f.mm = 0; f.fev = 0; f.fidx = 0; f.fo = '0; f.fe = '0;
    for (int i = 0; i < n; i++) begin
      if (ow[i] != ew[i]) begin
        f.mm++;
        mm_q.push_back(i + 1);
        if (!f.fev) begin
          f.fev = 1; f.fidx = i + 1; f.fo = ow[i]; f.fe = ew[i];
        end
      end else begin
        f.m++;
      end
    end
    fin_q.push_back(f);

    start = 1'b1;
    num_words = 16'(n);
    @(posedge clk); #1;
    start = 1'b0;
    k = 0; cyc = 0; gap = 0; mm_prev = 0;
    while (k < n && cyc < 2000) begin
      ov = 1; ev = 1;
      if (rnd) begin
        ov = ($urandom_range(0, 3) != 0);
        ev = ($urandom_range(0, 3) != 0);
      end
      if (k == gap_at && gap < 2) begin
        ev = 0;
        gap++;
      end
      out_valid = ov; exp_valid = ev;
      out_data = ow[k]; exp_data = ew[k];
      if (poke && cyc == 1) begin
        start = 1'b1;
        num_words = 16'(n + 3);
      end
      @(negedge clk);
      chk("pulse_timing", mismatch_pulse, mm_prev);
      chk("out_ready", out_ready, ev);
      chk("exp_ready", exp_ready, ov);
      chk("busy_in_run", busy, 1);
      @(posedge clk); #1;
      start = 1'b0;
      if (ov && ev) begin
        mm_prev = (ow[k] != ew[k]);
        k++;
      end else begin
        mm_prev = 0;
      end
      cyc++;
    end
    if (k < n) chk("run_timeout", k, n);

    // Both streams offer words in DONE; nothing may be accepted and results must hold.
    out_valid = 1'b1; exp_valid = 1'b1;
    @(negedge clk);
    chk("pulse_last", mismatch_pulse, mm_prev);
    chk("done_after_last", done, 1);
    chk("busy_after_last", busy, 0);
    chk("out_ready_done", out_ready, 0);
    chk("exp_ready_done", exp_ready, 0);
    @(posedge clk); #1;
    out_valid = 1'b0; exp_valid = 1'b0;
    @(negedge clk);
    chk("match_hold", match_count, f.m);
    chk("mismatch_hold", mismatch_count, f.mm);
    chk("done_hold", done, 1);
    chk("scoreboard_drained", fin_q.size() + mm_q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; num_words = '0;
    out_valid = 1'b0; out_data = '0; exp_valid = 1'b0; exp_data = '0;
    #1;
    check_zero("reset");
    @(negedge clk);
    reset = 1'b0;
    // No start yet: valid streams must not be accepted.
    out_valid = 1'b1; exp_valid = 1'b1;
    @(negedge clk);
    chk("idle_out_ready", out_ready, 0);
    chk("idle_busy", busy, 0);
    @(posedge clk); #1;
    out_valid = 1'b0; exp_valid = 1'b0;

    // Zero-length run from IDLE.
    ow = {}; ew = {};
    do_run(0, 0, -1, 0);

    // Four matching pairs back to back.
    ow = '{16'd1, 16'd2, 16'd3, 16'd4};
    ew = '{16'd1, 16'd2, 16'd3, 16'd4};
    do_run(4, 0, -1, 0);

    // Mismatches on pairs 2 and 3; first error captured at pair 2.
    ow = '{16'd5, 16'd9, 16'd7};
    ew = '{16'd5, 16'd8, 16'd6};
    do_run(3, 0, -1, 0);

    // Golden stream stalls for two cycles mid-stream.
    ow = '{16'h0a, 16'h0b, 16'h0c};
    ew = '{16'h0a, 16'h0b, 16'h0c};
    do_run(3, 0, 1, 0);

    // start pulsed while running is ignored; a following run from DONE starts clean.
    ow = '{16'h11, 16'h22, 16'h33};
    ew = '{16'h11, 16'h20, 16'h33};
    do_run(3, 0, -1, 1);
    ow = '{16'h44, 16'h55};
    ew = '{16'h44, 16'h55};
    do_run(2, 0, -1, 0);

    // Reset after two of five pairs wipes everything.
    start = 1'b1; num_words = 16'd5;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      out_valid = 1'b1; exp_valid = 1'b1;
      out_data = 16'(i + 1); exp_data = 16'(i + 1);
      @(posedge clk); #1;
    end
    chk("mid_run_busy", busy, 1);
    chk("mid_run_match", match_count, 2);
    reset = 1'b1;
    out_valid = 1'b0; exp_valid = 1'b0;
    #1;
    check_zero("mid_reset");
    @(negedge clk);
    reset = 1'b0;
    out_valid = 1'b1; exp_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("post_reset_out_ready", out_ready, 0);
      chk("post_reset_match", match_count, 0);
    end
    @(posedge clk); #1;
    out_valid = 1'b0; exp_valid = 1'b0;
    ow = '{16'h77};
    ew = '{16'h77};
    do_run(1, 0, -1, 0);

    // Randomized runs with stalls and single-bit corruptions.
    for (int r = 0; r < 25; r++) begin
      int n;
      n = $urandom_range(1, 12);
      ow = {}; ew = {};
      for (int i = 0; i < n; i++) begin
        logic [15:0] w;
        w = 16'($urandom);
        ow.push_back(w);
        if ($urandom_range(0, 1) == 0) ew.push_back(w);
        else ew.push_back(w ^ (16'd1 << $urandom_range(0, 15)));
      end
      do_run(n, 1, -1, ($urandom_range(0, 3) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
